// File: rtl/mem_stage.sv
// mem_stage: EX/MEM pipeline register, data-memory access controller and
// MEM/WB pipeline register of a 5-stage pipeline.
// Optional feature: define MEM_ALIGN_CHECK_EN to block misaligned word
// accesses and flag them on MisalignM instead of issuing a request.
//
// Memory handshake (dmem_req / dmem_ack): dmem_req is the valid and
// dmem_ack is the ready. A transfer completes in the cycle where both are 1.
// While dmem_req=1 and dmem_ack=0, dmem_req, dmem_we, dmem_addr and
// dmem_wdata stay stable. dmem_ack while dmem_req=0 has no effect.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        MemToRegE,
    input  logic        jumpE,
    input  logic [1:0]  MemWriteE,
    input  logic [31:0] ALUOutE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  WriteRegE,
    input  logic        FlushM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic [31:0] ALUOutM,
    output logic [4:0]  WriteRegM,
    output logic        RegWriteM,
    output logic        RegWriteW,
    output logic        MemToRegW,
    output logic        jumpW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic        MisalignM,
    output logic        stateDbg
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic        MemToRegM;
    logic        jumpM;
    logic [1:0]  MemWriteM;
    logic [31:0] WriteDataM;

    logic        memOpM;
    logic        isStoreM;
    logic        accessM;

    // EX/MEM register: hold while memory stalls, bubble on flush, else capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemToRegM  <= 1'b0;
            jumpM      <= 1'b0;
            MemWriteM  <= 2'b00;
            ALUOutM    <= 32'h0;
            WriteDataM <= 32'h0;
            WriteRegM  <= 5'd0;
        end else if (!StallM) begin
            if (FlushM) begin
                RegWriteM  <= 1'b0;
                MemToRegM  <= 1'b0;
                jumpM      <= 1'b0;
                MemWriteM  <= 2'b00;
                ALUOutM    <= 32'h0;
                WriteDataM <= 32'h0;
                WriteRegM  <= 5'd0;
            end else begin
                RegWriteM  <= RegWriteE;
                MemToRegM  <= MemToRegE;
                jumpM      <= jumpE;
                MemWriteM  <= MemWriteE;
                ALUOutM    <= ALUOutE;
                WriteDataM <= WriteDataE;
                WriteRegM  <= WriteRegE;
            end
        end
    end

    // A load takes priority over a simultaneous store encoding.
    assign memOpM   = MemToRegM | (MemWriteM == 2'b01);
    assign isStoreM = (MemWriteM == 2'b01) & ~MemToRegM;

`ifdef MEM_ALIGN_CHECK_EN
    assign accessM   = memOpM & (ALUOutM[1:0] == 2'b00);
    assign MisalignM = memOpM & (ALUOutM[1:0] != 2'b00);
`else
    assign accessM   = memOpM;
    assign MisalignM = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next state and memory request outputs; request is combinational
    // off the held EX/MEM contents, so it is stable across WAIT cycles
    always_comb begin
        stateNext  = state;
        StallM     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        if (accessM) begin
            dmem_req   = 1'b1;
            dmem_we    = isStoreM;
            dmem_addr  = {ALUOutM[31:2], 2'b00};
            dmem_wdata = WriteDataM;
        end
        case (state)
            IDLE: begin
                if (accessM && !dmem_ack) begin
                    StallM    = 1'b1;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (accessM && !dmem_ack) begin
                    StallM = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign stateDbg = (state == WAIT);

    // MEM/WB register: bubble while stalled, else capture the completing op
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
            jumpW     <= 1'b0;
            ReadDataW <= 32'h0;
            ALUOutW   <= 32'h0;
            WriteRegW <= 5'd0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
            jumpW     <= 1'b0;
            ReadDataW <= 32'h0;
            ALUOutW   <= 32'h0;
            WriteRegW <= 5'd0;
        end else begin
            RegWriteW <= RegWriteM & ~MisalignM;
            MemToRegW <= MemToRegM;
            jumpW     <= jumpM;
            ReadDataW <= (MemToRegM && accessM) ? dmem_rdata : 32'h0;
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: reset checks, a table of directed single
// instructions, reset during a memory wait, and a randomized instruction
// stream checked against a schedule-based reference model.
module tb_mem_stage;

    localparam int NPROG = 150;
    localparam int MAXC  = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        RegWriteE, MemToRegE, jumpE;
    logic [1:0]  MemWriteE;
    logic [31:0] ALUOutE, WriteDataE;
    logic [4:0]  WriteRegE;
    logic        FlushM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic [31:0] ALUOutM;
    logic [4:0]  WriteRegM;
    logic        RegWriteM;
    logic        RegWriteW, MemToRegW, jumpW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  WriteRegW;
    logic        MisalignM;
    logic        stateDbg;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .jumpE(jumpE),
        .MemWriteE(MemWriteE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
        .WriteRegE(WriteRegE), .FlushM(FlushM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .jumpW(jumpW), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
        .WriteRegW(WriteRegW), .MisalignM(MisalignM), .stateDbg(stateDbg)
    );

    // ---------------- scoreboard counters ----------------
    int nVec = 0;
    int nMis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- types ----------------
    typedef struct {
        logic        regWrite;
        logic        memToReg;
        logic        jump;
        logic [1:0]  memWrite;
        logic [31:0] aluOut;
        logic [31:0] writeData;
        logic [4:0]  writeReg;
        logic        flush;
    } instr_t;

    typedef struct {
        string       name;
        instr_t      in;
        int          waitCyc;
        logic [31:0] rdata;
        int          expReqCyc;
        int          expStallCyc;
        int          expMisCyc;
        logic        expWe;
        logic [31:0] expAddr;
        logic        expRegWriteM;
        logic        expRegWriteW;
        logic        expMemToRegW;
        logic        expJumpW;
        logic [31:0] expReadDataW;
        logic [31:0] expAluOutW;
        logic [4:0]  expWriteRegW;
    } vec_t;

    vec_t vecs[8];

    // ---------------- driver tasks ----------------
    task automatic driveE(input instr_t i);
        RegWriteE  = i.regWrite;
        MemToRegE  = i.memToReg;
        jumpE      = i.jump;
        MemWriteE  = i.memWrite;
        ALUOutE    = i.aluOut;
        WriteDataE = i.writeData;
        WriteRegE  = i.writeReg;
    endtask

    task automatic clearE();
        RegWriteE  = 1'b0;
        MemToRegE  = 1'b0;
        jumpE      = 1'b0;
        MemWriteE  = 2'b00;
        ALUOutE    = 32'h0;
        WriteDataE = 32'h0;
        WriteRegE  = 5'd0;
    endtask

    // Issue one instruction into an otherwise empty pipe, answer its memory
    // access after v.waitCyc wait cycles, then check what reaches writeback.
    // Entered and left at posedge+1.
    task automatic runVec(input vec_t v);
        int  reqCyc   = 0;
        int  stallCyc = 0;
        int  misCyc   = 0;
        int  badReq   = 0;
        bit  done     = 0;
        driveE(v.in);
        FlushM   = v.in.flush;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        clearE();
        FlushM = 1'b0;
        chk({v.name, ".RegWriteM"}, 32'(RegWriteM), 32'(v.expRegWriteM));
        for (int j = 0; j < 16 && !done; j++) begin
            dmem_ack   = (j == v.waitCyc);
            dmem_rdata = v.rdata;
            @(negedge clk);
            if (dmem_req) begin
                reqCyc++;
                if (dmem_we !== v.expWe || dmem_addr !== v.expAddr || dmem_wdata !== v.in.writeData)
                    badReq++;
            end
            if (StallM)    stallCyc++;
            if (MisalignM) misCyc++;
            if (!StallM)   done = 1;
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        chk({v.name, ".completed"}, 32'(done), 32'd1);
        chk({v.name, ".reqCycles"}, 32'(reqCyc), 32'(v.expReqCyc));
        chk({v.name, ".stallCycles"}, 32'(stallCyc), 32'(v.expStallCyc));
        chk({v.name, ".misalignCycles"}, 32'(misCyc), 32'(v.expMisCyc));
        chk({v.name, ".badReqFields"}, 32'(badReq), 32'd0);
        chk({v.name, ".RegWriteW"}, 32'(RegWriteW), 32'(v.expRegWriteW));
        chk({v.name, ".MemToRegW"}, 32'(MemToRegW), 32'(v.expMemToRegW));
        chk({v.name, ".jumpW"}, 32'(jumpW), 32'(v.expJumpW));
        chk({v.name, ".ReadDataW"}, ReadDataW, v.expReadDataW);
        chk({v.name, ".ALUOutW"}, ALUOutW, v.expAluOutW);
        chk({v.name, ".WriteRegW"}, 32'(WriteRegW), 32'(v.expWriteRegW));
    endtask

    // ---------------- random-phase reference model ----------------
    // Transaction schedule: each instruction occupies M for (wait+1) cycles
    // if it accesses memory, else 1 cycle; it reaches W the cycle after it
    // leaves M, and stalled M cycles deliver empty writeback slots.
    instr_t      prog[NPROG];
    int          waitArr[NPROG];
    int          eIdx[MAXC];
    logic        flushArr[MAXC];
    logic        ackArr[MAXC];
    logic [31:0] rdataArr[MAXC];
    logic        expReq[MAXC], expWe[MAXC], expStall[MAXC], expMisal[MAXC];
    logic [31:0] expAddr[MAXC], expWdata[MAXC], expAluM[MAXC];
    logic        expRwM[MAXC];
    logic [4:0]  expWrM[MAXC];
    logic        expRwW[MAXC], expMtrW[MAXC], expJmpW[MAXC];
    logic [31:0] expRdW[MAXC], expAluW[MAXC];
    logic [4:0]  expWrW[MAXC];
    int          nCycles;

    task automatic buildModel();
        int     start     = 1;
        int     prevStart = 0;
        instr_t eff;
        logic   memOp, aligned, access, mis;
        int     occ;
        for (int c = 0; c < MAXC; c++) begin
            eIdx[c] = -1;
            flushArr[c] = 1'($urandom_range(0, 1));
            ackArr[c] = 1'($urandom_range(0, 1));
            rdataArr[c] = $urandom;
            expReq[c] = 0; expWe[c] = 0; expStall[c] = 0; expMisal[c] = 0;
            expAddr[c] = 0; expWdata[c] = 0; expAluM[c] = 0; expRwM[c] = 0; expWrM[c] = 0;
            expRwW[c] = 0; expMtrW[c] = 0; expJmpW[c] = 0; expRdW[c] = 0; expAluW[c] = 0; expWrW[c] = 0;
        end
        for (int k = 0; k < NPROG; k++) begin
            prog[k].regWrite  = 1'($urandom_range(0, 1));
            prog[k].memToReg  = ($urandom_range(0, 2) == 0);
            prog[k].jump      = 1'($urandom_range(0, 1));
            prog[k].memWrite  = 2'($urandom_range(0, 3));
            prog[k].aluOut    = $urandom;
            prog[k].writeData = $urandom;
            prog[k].writeReg  = 5'($urandom_range(0, 31));
            prog[k].flush     = ($urandom_range(0, 7) == 0);
            waitArr[k]        = $urandom_range(0, 3);
            for (int c = prevStart; c < start; c++) eIdx[c] = k;
            flushArr[start - 1] = prog[k].flush;
            eff = prog[k];
            if (eff.flush) eff = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0};
            memOp = eff.memToReg || (eff.memWrite == 2'b01);
`ifdef MEM_ALIGN_CHECK_EN
            aligned = (eff.aluOut[1:0] == 2'b00);
`else
            aligned = 1'b1;
`endif
            access = memOp && aligned;
            mis    = memOp && !aligned;
            occ    = access ? waitArr[k] + 1 : 1;
            for (int j = 0; j < occ; j++) begin
                int c = start + j;
                expReq[c]   = access;
                expWe[c]    = access && !eff.memToReg;
                expAddr[c]  = eff.aluOut & 32'hFFFF_FFFC;
                expWdata[c] = eff.writeData;
                expStall[c] = access && (j < waitArr[k]);
                expMisal[c] = mis;
                expRwM[c]   = eff.regWrite;
                expAluM[c]  = eff.aluOut;
                expWrM[c]   = eff.writeReg;
                if (access) ackArr[c] = (j == waitArr[k]);
                if (j == occ - 1) begin
                    expRwW[c + 1]  = eff.regWrite && !mis;
                    expMtrW[c + 1] = eff.memToReg;
                    expJmpW[c + 1] = eff.jump;
                    expAluW[c + 1] = eff.aluOut;
                    expWrW[c + 1]  = eff.writeReg;
                    expRdW[c + 1]  = (eff.memToReg && access) ? rdataArr[c] : 32'h0;
                end
            end
            prevStart = start;
            start     = start + occ;
        end
        nCycles = start + 2;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- main test ----------------
    initial begin
        rst = 1'b0;
        clearE();
        FlushM     = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;

        // Reset state
        @(posedge clk); #1;
        chk("reset.dmem_req", 32'(dmem_req), 32'd0);
        chk("reset.StallM", 32'(StallM), 32'd0);
        chk("reset.MisalignM", 32'(MisalignM), 32'd0);
        chk("reset.RegWriteW", 32'(RegWriteW), 32'd0);
        chk("reset.ALUOutM", ALUOutM, 32'h0);
        chk("reset.state", 32'(stateDbg), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Directed table
        vecs[0] = '{"store", '{1'b0, 1'b0, 1'b0, 2'b01, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0}, 0, 32'h0,
                    1, 0, 0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h100, 5'd0};
        vecs[1] = '{"load_wait", '{1'b1, 1'b1, 1'b0, 2'b00, 32'h40, 32'h0, 5'd5, 1'b0}, 2, 32'h12345678,
                    3, 2, 0, 1'b0, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0, 32'h12345678, 32'h40, 5'd5};
        vecs[2] = '{"flush", '{1'b1, 1'b1, 1'b0, 2'b00, 32'h80, 32'h0, 5'd7, 1'b1}, 0, 32'hCAFEF00D,
                    0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0};
        vecs[3] = '{"mfhi", '{1'b1, 1'b0, 1'b0, 2'b11, 32'hA5A5, 32'h1111, 5'd9, 1'b0}, 0, 32'h55,
                    0, 0, 0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hA5A5, 5'd9};
        vecs[4] = '{"mflo_jump", '{1'b1, 1'b0, 1'b1, 2'b10, 32'h777, 32'h0, 5'd3, 1'b0}, 2, 32'h99,
                    0, 0, 0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h777, 5'd3};
`ifdef MEM_ALIGN_CHECK_EN
        vecs[5] = '{"load_misaligned", '{1'b1, 1'b1, 1'b0, 2'b00, 32'h41, 32'h0, 5'd6, 1'b0}, 0, 32'hABCD0123,
                    0, 0, 1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h41, 5'd6};
`else
        vecs[5] = '{"load_misaligned", '{1'b1, 1'b1, 1'b0, 2'b00, 32'h41, 32'h0, 5'd6, 1'b0}, 0, 32'hABCD0123,
                    1, 0, 0, 1'b0, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0, 32'hABCD0123, 32'h41, 5'd6};
`endif
        vecs[6] = '{"store_wait", '{1'b0, 1'b0, 1'b0, 2'b01, 32'h2004, 32'h0BADF00D, 5'd2, 1'b0}, 1, 32'h0,
                    2, 1, 0, 1'b1, 32'h2004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h2004, 5'd2};
        vecs[7] = '{"nop_ack_noise", '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0}, 0, 32'hFFFF,
                    0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0};
        for (int i = 0; i < 8; i++) runVec(vecs[i]);

        // Reset asserted while waiting on memory
        driveE('{1'b1, 1'b1, 1'b0, 2'b00, 32'h300, 32'h0, 5'd4, 1'b0});
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        clearE();
        @(negedge clk);
        chk("rstwait.StallM_before", 32'(StallM), 32'd1);
        @(posedge clk); #1;
        chk("rstwait.state_wait", 32'(stateDbg), 32'd1);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstwait.dmem_req", 32'(dmem_req), 32'd0);
        chk("rstwait.StallM", 32'(StallM), 32'd0);
        chk("rstwait.state", 32'(stateDbg), 32'd0);
        chk("rstwait.ALUOutM", ALUOutM, 32'h0);
        chk("rstwait.RegWriteW", 32'(RegWriteW), 32'd0);
        chk("rstwait.ReadDataW", ReadDataW, 32'h0);
        chk("rstwait.WriteRegW", 32'(WriteRegW), 32'd0);
        driveE('{1'b0, 1'b0, 1'b0, 2'b01, 32'h500, 32'h13579BDF, 5'd0, 1'b0});
        @(posedge clk); #1;
        chk("rstwait.held_in_reset", ALUOutM, 32'h0);
        rst = 1'b1;
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        chk("rstwait.first_capture", ALUOutM, 32'h500);
        clearE();
        @(negedge clk);
        chk("rstwait.store_req", 32'(dmem_req), 32'd1);
        chk("rstwait.store_addr", dmem_addr, 32'h500);
        @(posedge clk); #1;
        dmem_ack = 1'b0;

        // Randomized instruction stream
        buildModel();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < nCycles; c++) begin
            if (eIdx[c] >= 0) driveE(prog[eIdx[c]]);
            else clearE();
            FlushM     = flushArr[c];
            dmem_ack   = ackArr[c];
            dmem_rdata = rdataArr[c];
            @(negedge clk);
            chk($sformatf("rnd.StallM@%0d", c), 32'(StallM), 32'(expStall[c]));
            chk($sformatf("rnd.dmem_req@%0d", c), 32'(dmem_req), 32'(expReq[c]));
            if (expReq[c]) begin
                chk($sformatf("rnd.dmem_we@%0d", c), 32'(dmem_we), 32'(expWe[c]));
                chk($sformatf("rnd.dmem_addr@%0d", c), dmem_addr, expAddr[c]);
                chk($sformatf("rnd.dmem_wdata@%0d", c), dmem_wdata, expWdata[c]);
            end
            chk($sformatf("rnd.MisalignM@%0d", c), 32'(MisalignM), 32'(expMisal[c]));
            chk($sformatf("rnd.RegWriteM@%0d", c), 32'(RegWriteM), 32'(expRwM[c]));
            chk($sformatf("rnd.ALUOutM@%0d", c), ALUOutM, expAluM[c]);
            chk($sformatf("rnd.WriteRegM@%0d", c), 32'(WriteRegM), 32'(expWrM[c]));
            chk($sformatf("rnd.RegWriteW@%0d", c), 32'(RegWriteW), 32'(expRwW[c]));
            chk($sformatf("rnd.MemToRegW@%0d", c), 32'(MemToRegW), 32'(expMtrW[c]));
            chk($sformatf("rnd.jumpW@%0d", c), 32'(jumpW), 32'(expJmpW[c]));
            chk($sformatf("rnd.ReadDataW@%0d", c), ReadDataW, expRdW[c]);
            chk($sformatf("rnd.ALUOutW@%0d", c), ALUOutW, expAluW[c]);
            chk($sformatf("rnd.WriteRegW@%0d", c), 32'(WriteRegW), 32'(expWrW[c]));
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
